// File: rtl/calc_ctrl.sv
// Sequencer for the calculator datapath: clears the register file, then runs load A, load B, execute, hold.
// done is asserted 4 cycles after go is accepted and held until go falls; all outputs are Moore.
module calc_ctrl #(
  parameter int addr_size = 2,
  parameter int rf_size   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [addr_size-1:0] op,
  output logic [addr_size-1:0] s1,
  output logic [addr_size-1:0] wa,
  output logic                 we,
  output logic [addr_size-1:0] raa,
  output logic                 rea,
  output logic [addr_size-1:0] rab,
  output logic                 reb,
  output logic [addr_size-1:0] c,
  output logic                 s2,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_EXEC   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [addr_size-1:0] SEL_IN1  = addr_size'(0);
  localparam logic [addr_size-1:0] SEL_IN2  = addr_size'(1);
  localparam logic [addr_size-1:0] SEL_ZERO = addr_size'(2);
  localparam logic [addr_size-1:0] SEL_ALU  = addr_size'(3);
  localparam logic [addr_size-1:0] REG_R1   = addr_size'(1);
  localparam logic [addr_size-1:0] REG_R2   = addr_size'(2);
  localparam logic [addr_size-1:0] REG_R3   = addr_size'(3);
  localparam logic [addr_size-1:0] CLR_LAST = addr_size'(rf_size - 1);

  state_t               state_q, state_d;
  logic [addr_size-1:0] clr_cnt_q, clr_cnt_d;
  logic [addr_size-1:0] op_q, op_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      op_q      <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    op_d      = op_q;
    s1        = SEL_ZERO;
    wa        = '0;
    we        = 1'b0;
    raa       = '0;
    rea       = 1'b0;
    rab       = '0;
    reb       = 1'b0;
    c         = op_q;
    s2        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_INIT: begin
        wa = clr_cnt_q;
        we = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + addr_size'(1);
        end
      end
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          op_d    = op;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        s1      = SEL_IN1;
        wa      = REG_R1;
        we      = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        s1      = SEL_IN2;
        wa      = REG_R2;
        we      = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        rea     = 1'b1;
        raa     = REG_R1;
        reb     = 1'b1;
        rab     = REG_R2;
        s1      = SEL_ALU;
        wa      = REG_R3;
        we      = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Read ports stay on R1/R2 so the ALU keeps presenting the result.
        rea  = 1'b1;
        raa  = REG_R1;
        reb  = 1'b1;
        rab  = REG_R2;
        s2   = 1'b1;
        done = 1'b1;
        if (!go) state_d = S_IDLE;
      end
      default: begin
        clr_cnt_d = '0;
        state_d   = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: vector table, datapath-level operation checks, and randomized run against a step model.
module tb_calc_ctrl;

  logic       clk = 1'b0;
  logic       rst, go;
  logic [1:0] op;
  logic [1:0] s1, wa, raa, rab, c;
  logic       we, rea, reb, s2, busy, done;

  always #5 clk = ~clk;

  calc_ctrl #(.addr_size(2), .rf_size(4)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op),
    .s1(s1), .wa(wa), .we(we), .raa(raa), .rea(rea), .rab(rab), .reb(reb),
    .c(c), .s2(s2), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [1:0] s1; logic [1:0] wa; logic we;
    logic [1:0] raa; logic rea; logic [1:0] rab; logic reb;
    logic [1:0] c; logic s2; logic busy; logic done;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       go;
    logic [1:0] op;
    outs_t      exp;
  } vec_t;

  outs_t dut_o;
  assign dut_o = {s1, wa, we, raa, rea, rab, reb, c, s2, busy, done};

  // Small behavioural datapath: 4 x 3-bit register file, input mux, ALU, output mux.
  logic [2:0] rf [4];
  logic [2:0] in1, in2, a_rd, b_rd, aluout, dp_in, dp_out;

  function automatic logic [2:0] alu(input logic [1:0] f, input logic [2:0] a, input logic [2:0] b);
    case (f)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign a_rd   = rea ? rf[raa] : 3'd0;
  assign b_rd   = reb ? rf[rab] : 3'd0;
  assign aluout = alu(c, a_rd, b_rd);
  assign dp_in  = (s1 == 2'd0) ? in1 : (s1 == 2'd1) ? in2 : (s1 == 2'd2) ? 3'd0 : aluout;
  assign dp_out = s2 ? aluout : 3'd0;

  always @(posedge clk) if (we) rf[wa] <= dp_in;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[$];

  function automatic outs_t mk(input logic [1:0] xs1, input logic [1:0] xwa, input logic xwe,
                               input logic rd, input logic [1:0] xc, input logic xs2,
                               input logic xbusy, input logic xdone);
    outs_t o;
    o.s1 = xs1; o.wa = xwa; o.we = xwe;
    o.raa = rd ? 2'b01 : 2'b00; o.rea = rd;
    o.rab = rd ? 2'b10 : 2'b00; o.reb = rd;
    o.c = xc; o.s2 = xs2; o.busy = xbusy; o.done = xdone;
    return o;
  endfunction

  task automatic add(input logic r, input logic g, input logic [1:0] o, input outs_t e);
    vec_t v;
    v.rst = r; v.go = g; v.op = o; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input outs_t exp);
    n_tests++;
    if (dut_o !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, dut_o, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: clearing progress, operation step (0 idle .. 4 holding result), captured op.
  int         m_init;
  int         m_step;
  logic [1:0] m_op;

  task automatic model_edge(input logic r, input logic g, input logic [1:0] o);
    if (r) begin
      m_init = 0; m_step = 0; m_op = 2'd0;
    end else if (m_init >= 0) begin
      m_init = (m_init == 3) ? -1 : m_init + 1;
    end else if (m_step == 0) begin
      if (g) begin m_op = o; m_step = 1; end
    end else if (m_step < 4) begin
      m_step = m_step + 1;
    end else if (!g) begin
      m_step = 0;
    end
  endtask

  function automatic outs_t model_exp();
    if (m_init >= 0) return mk(2'd2, 2'(m_init), 1'b1, 1'b0, m_op, 1'b0, 1'b1, 1'b0);
    case (m_step)
      1:       return mk(2'd0, 2'd1, 1'b1, 1'b0, m_op, 1'b0, 1'b1, 1'b0);
      2:       return mk(2'd1, 2'd2, 1'b1, 1'b0, m_op, 1'b0, 1'b1, 1'b0);
      3:       return mk(2'd3, 2'd3, 1'b1, 1'b1, m_op, 1'b0, 1'b1, 1'b0);
      4:       return mk(2'd2, 2'd0, 1'b0, 1'b1, m_op, 1'b1, 1'b1, 1'b1);
      default: return mk(2'd2, 2'd0, 1'b0, 1'b0, m_op, 1'b0, 1'b0, 1'b0);
    endcase
  endfunction

  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] f, input string nm);
    int k;
    in1 = a; in2 = b; op = f; go = 1'b1;
    tick();
    go = 1'b0;
    op = ~f;
    k = 0;
    while (!done && k < 8) begin
      tick();
      k++;
    end
    check_val({nm, "_latency"}, 32'(k), 32'd3);
    check_val({nm, "_out"}, 32'(dp_out), 32'(alu(f, a, b)));
    check_val({nm, "_r3"}, 32'(rf[3]), 32'(alu(f, a, b)));
    tick();
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; op = 2'd0; in1 = 3'd0; in2 = 3'd0;

    // reset, clear sweep, first operation
    add(1, 0, 0, mk(2, 0, 1, 0, 0, 0, 1, 0));
    add(1, 0, 0, mk(2, 0, 1, 0, 0, 0, 1, 0));
    add(0, 0, 0, mk(2, 1, 1, 0, 0, 0, 1, 0));
    add(0, 0, 0, mk(2, 2, 1, 0, 0, 0, 1, 0));
    add(0, 0, 0, mk(2, 3, 1, 0, 0, 0, 1, 0));
    add(0, 0, 0, mk(2, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, mk(0, 1, 1, 0, 0, 0, 1, 0));
    add(0, 0, 3, mk(1, 2, 1, 0, 0, 0, 1, 0));
    add(0, 0, 3, mk(3, 3, 1, 1, 0, 0, 1, 0));
    add(0, 0, 3, mk(2, 0, 0, 1, 0, 1, 1, 1));
    add(0, 0, 3, mk(2, 0, 0, 0, 0, 0, 0, 0));
    // go held, op changes after acceptance
    add(0, 1, 1, mk(0, 1, 1, 0, 1, 0, 1, 0));
    add(0, 1, 2, mk(1, 2, 1, 0, 1, 0, 1, 0));
    add(0, 1, 2, mk(3, 3, 1, 1, 1, 0, 1, 0));
    add(0, 1, 2, mk(2, 0, 0, 1, 1, 1, 1, 1));
    add(0, 1, 2, mk(2, 0, 0, 1, 1, 1, 1, 1));
    add(0, 0, 2, mk(2, 0, 0, 0, 1, 0, 0, 0));
    // reset during EXEC
    add(0, 1, 3, mk(0, 1, 1, 0, 3, 0, 1, 0));
    add(0, 0, 3, mk(1, 2, 1, 0, 3, 0, 1, 0));
    add(0, 0, 3, mk(3, 3, 1, 1, 3, 0, 1, 0));
    add(1, 0, 3, mk(2, 0, 1, 0, 0, 0, 1, 0));
    // go held through INIT, accepted on first IDLE cycle
    add(0, 1, 2, mk(2, 1, 1, 0, 0, 0, 1, 0));
    add(0, 1, 2, mk(2, 2, 1, 0, 0, 0, 1, 0));
    add(0, 1, 2, mk(2, 3, 1, 0, 0, 0, 1, 0));
    add(0, 1, 2, mk(2, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 2, mk(0, 1, 1, 0, 2, 0, 1, 0));
    add(0, 0, 2, mk(1, 2, 1, 0, 2, 0, 1, 0));
    add(0, 0, 2, mk(3, 3, 1, 1, 2, 0, 1, 0));
    add(0, 0, 2, mk(2, 0, 0, 1, 2, 1, 1, 1));
    add(0, 0, 2, mk(2, 0, 0, 0, 2, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; go = vt[i].go; op = vt[i].op;
      tick();
      check($sformatf("vec%0d", i), vt[i].exp);
    end

    // Clearing sweep empties the register file after it held operation results.
    rst = 1'b1; go = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_val("rf_cleared", 32'({rf[0], rf[1], rf[2], rf[3]}), 32'd0);
    check_val("idle_after_init", 32'(busy), 32'd0);

    run_op(3'b011, 3'b001, 2'd0, "op_add");
    for (int i = 0; i < 6; i++)
      run_op(3'($urandom), 3'($urandom), 2'($urandom), $sformatf("op_rand%0d", i));

    // Reset landing on EXEC still lets the R3 write complete.
    in1 = 3'd6; in2 = 3'd3; op = 2'd1; go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick();
    check_val("exec_before_rst", 32'({s1, wa, we}), 32'({2'd3, 2'd3, 1'b1}));
    rst = 1'b1;
    tick();
    check_val("r3_on_rst_edge", 32'(rf[3]), 32'(alu(2'd1, 3'd6, 3'd3)));
    rst = 1'b0;

    // Randomized run against the step model.
    rst = 1'b1;
    model_edge(1'b1, 1'b0, 2'd0);
    tick();
    check("rand_reset", model_exp());
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      go  = ($urandom_range(0, 2) != 0);
      op  = 2'($urandom);
      model_edge(rst, go, op);
      tick();
      check($sformatf("rand%0d", i), model_exp());
      n_tests++;
      if ((s2 !== done) || (we && (!busy || done))) begin
        n_fail++;
        $display("FAIL inv%0d: got s2=%b done=%b we=%b busy=%b required s2==done, we=0 when idle or done",
                 i, s2, done, we, busy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Control unit that sequences the calculator datapath (mux-select, register-file, ALU, output-mux controls) through one complete operation.
- After reset it clears all register-file entries, then waits for `go`.
- On `go` it loads operand A from `in1` into R1 and operand B from `in2` into R2, executes the latched ALU op, writes the result to R3, and presents the result on the datapath output until `go` is released.
- Sits beside the datapath and drives every datapath control input except `clk`.

Parameters:
- addr_size, 2, width of register addresses and ALU op code
- rf_size, 4, number of register-file entries cleared in INIT (must equal 2**addr_size)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- go  input  1  start request, level; sampled only in IDLE
- op  input  addr_size  ALU op code; latched into op_q when go is accepted
- s1  output  addr_size  input-mux select: 00 in1, 01 in2, 10 zero, 11 aluout
- wa  output  addr_size  register-file write address
- we  output  1  register-file write enable
- raa  output  addr_size  read address, port A
- rea  output  1  read enable, port A
- rab  output  addr_size  read address, port B
- reb  output  1  read enable, port B
- c  output  addr_size  ALU op code
- s2  output  1  output-mux select: 1 aluout, 0 zero
- busy  output  1  high in every state except IDLE
- done  output  1  high only in DONE; datapath output valid

Behaviour:
- Reset: synchronous, active-high, on `clk` rising edge.
  - state <= INIT, clr_cnt <= 0, op_q <= 0.
  - Dominates all other inputs, including mid-operation; any in-flight operation is abandoned.
- Outputs: Moore decode of state, clr_cnt and op_q.
- Default output values, wherever a state does not override them:
  - we=0, rea=0, reb=0, s2=0, done=0
  - s1=10, wa=00, raa=00, rab=00, c=op_q
  - busy=1
- Output values while `rst` is high are the INIT values with clr_cnt=0: s1=10, wa=00, we=1, busy=1, done=0, s2=0. Writing zero to R0 during reset is intentional and harmless.
- INIT:
  - s1=10, wa=clr_cnt, we=1.
  - clr_cnt increments every cycle.
  - When clr_cnt=rf_size-1, go to IDLE. Takes exactly rf_size cycles.
  - `go` is ignored (not latched) in INIT.
- IDLE:
  - busy=0, all enables 0.
  - If go=1: op_q <= op, go to LOAD_A.
- LOAD_A: s1=00, wa=01, we=1 → LOAD_B.
- LOAD_B: s1=01, wa=10, we=1 → EXEC.
- EXEC: rea=1, raa=01, reb=1, rab=10, c=op_q, s1=11, wa=11, we=1 → DONE.
- DONE:
  - rea=1, raa=01, reb=1, rab=10, c=op_q, s2=1, done=1.
  - Remain while go=1; when go=0, go to IDLE.
- Latency: go sampled high at edge k → LOAD_A in cycle k+1 → done=1 from cycle k+4. Minimum busy period is 4 cycles.
- Operands: `in1`/`in2` must be stable during LOAD_A/LOAD_B respectively; the controller does not register them.
- `op` changes after acceptance are ignored; c follows op_q only.
- Back-to-back operations: go held high through DONE → no new operation. Go must fall (DONE→IDLE) and then rise again.
- go=1 at IDLE exit of INIT (first IDLE cycle) is accepted normally.
- Illegal state encodings → INIT on next edge.
- No output depends combinationally on `go` or `op`.

Test Plan:
- Reset for 2 cycles, then release → exactly 4 cycles of we=1 with wa=00,01,10,11 and s1=10; busy=0 in cycle 5; datapath R0..R3 read back 000.
- In IDLE, in1=3'b011, in2=3'b001, op=00, go pulse 1 cycle → LOAD_A, LOAD_B, EXEC, DONE on consecutive cycles; done=1 exactly one cycle; datapath out equals ALU(011,001,op00) and R3 holds the same value.
- go held high, op switched from 01 to 10 during LOAD_B → c=01 throughout EXEC/DONE; state stays DONE until go=0, then IDLE next cycle, busy=0.
- rst asserted during EXEC → next cycle state INIT, we=1, wa=00, s1=10, done=0, s2=0; the R3 write of that EXEC is still allowed only in the cycle before the reset edge.
- go=1 during INIT → ignored until IDLE is reached; accepted in the first IDLE cycle, LOAD_A follows immediately.
- Every cycle, all states: s2=1 iff done=1; we=0 in IDLE and DONE; busy=~(state==IDLE).
